vx_om_hazard_sched: RTL

- Issue controller in front of the OM blend/ROP datapath.
- Admits pixel-quad requests only when no in-flight request covers the same framebuffer pixel. This preserves read-modify-write ordering for depth, stencil and blend.
- Assigns each admitted request a tag and holds its lane positions until the datapath retires that tag.
- Sits between the OM request arbiter output and the OM memory/blend pipeline.

---
 rtl/vx_om_hazard_sched_pkg.sv | 18 +
 rtl/vx_om_hazard_sched_cam.sv | 32 +++
 rtl/vx_om_hazard_sched.sv | 91 +++++++++
 3 files changed

// File: rtl/vx_om_hazard_sched_pkg.sv
// vx_om_hazard_sched_pkg: shared sizing helpers and entry type for the OM hazard scheduler
`ifndef VX_OM_DIM_BITS
`define VX_OM_DIM_BITS 16
`endif
package vx_om_hazard_sched_pkg;
  localparam int OM_NUM_LANES = 4;
  localparam int OM_MAX_PENDING = 8;
  localparam int OM_DIM_BITS = `VX_OM_DIM_BITS;
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int OM_TAG_W = tag_w(OM_MAX_PENDING);
  typedef struct packed {
    logic [OM_NUM_LANES-1:0] mask;
    logic [OM_NUM_LANES-1:0][OM_DIM_BITS-1:0] pos_x;
    logic [OM_NUM_LANES-1:0][OM_DIM_BITS-1:0] pos_y;
  } om_hazard_entry_t;
endpackage

// File: rtl/vx_om_hazard_sched_cam.sv
// vx_om_hazard_sched_cam: combinational lane-position compare against the in-flight table plus free-slot pick
module vx_om_hazard_sched_cam import vx_om_hazard_sched_pkg::*; #(
  parameter int NUM_LANES = OM_NUM_LANES,
  parameter int MAX_PENDING = OM_MAX_PENDING,
  parameter int DIM_BITS = OM_DIM_BITS,
  parameter int TAG_W = tag_w(MAX_PENDING)
) (
  input  logic [MAX_PENDING-1:0]                         ent_valid,
  input  logic [MAX_PENDING-1:0][NUM_LANES-1:0]          ent_mask,
  input  logic [MAX_PENDING-1:0][NUM_LANES*DIM_BITS-1:0] ent_x,
  input  logic [MAX_PENDING-1:0][NUM_LANES*DIM_BITS-1:0] ent_y,
  input  logic [NUM_LANES-1:0]                           in_mask,
  input  logic [NUM_LANES*DIM_BITS-1:0]                  in_pos_x,
  input  logic [NUM_LANES*DIM_BITS-1:0]                  in_pos_y,
  output logic                                           hazard,
  output logic                                           has_free,
  output logic [TAG_W-1:0]                               free_idx
);
  always_comb begin
    hazard = 1'b0;
    free_idx = '0;
    for (int e = MAX_PENDING - 1; e >= 0; e--) begin
      if (!ent_valid[e]) free_idx = TAG_W'(e);
      for (int i = 0; i < NUM_LANES; i++)
        for (int j = 0; j < NUM_LANES; j++)
          hazard |= ent_valid[e] & in_mask[i] & ent_mask[e][j]
                  & (in_pos_x[i*DIM_BITS +: DIM_BITS] == ent_x[e][j*DIM_BITS +: DIM_BITS])
                  & (in_pos_y[i*DIM_BITS +: DIM_BITS] == ent_y[e][j*DIM_BITS +: DIM_BITS]);
    end
  end
  assign has_free = ~&ent_valid;
endmodule

// File: rtl/vx_om_hazard_sched.sv
// vx_om_hazard_sched: admits OM pixel quads only when no in-flight quad touches the same pixel, tags them until retired
// Optional perf counters via VX_OM_HAZARD_PERF_EN.
module vx_om_hazard_sched import vx_om_hazard_sched_pkg::*; #(
  parameter int NUM_LANES = OM_NUM_LANES,
  parameter int MAX_PENDING = OM_MAX_PENDING,
  parameter int DATAW = 64,
  parameter int DIM_BITS = OM_DIM_BITS,
  localparam int TAG_W = tag_w(MAX_PENDING),
  localparam int CNT_W = $clog2(MAX_PENDING + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [NUM_LANES-1:0]          in_mask,
  input  logic [NUM_LANES*DIM_BITS-1:0] in_pos_x,
  input  logic [NUM_LANES*DIM_BITS-1:0] in_pos_y,
  input  logic [DATAW-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [TAG_W-1:0]              out_tag,
  output logic [NUM_LANES-1:0]          out_mask,
  output logic [DATAW-1:0]              out_data,
  input  logic                          out_ready,
  input  logic                          done_valid,
  input  logic [TAG_W-1:0]              done_tag,
  output logic [CNT_W-1:0]              pending_cnt
`ifdef VX_OM_HAZARD_PERF_EN
  ,
  output logic [43:0]                   perf_hazard_stalls,
  output logic [43:0]                   perf_full_stalls
`endif
);
  logic [MAX_PENDING-1:0] ent_valid;
  logic [MAX_PENDING-1:0][NUM_LANES-1:0] ent_mask;
  logic [MAX_PENDING-1:0][NUM_LANES*DIM_BITS-1:0] ent_x, ent_y;
  logic hazard, has_free, fire, retire;
  logic [TAG_W-1:0] free_idx;
  vx_om_hazard_sched_cam #(
    .NUM_LANES(NUM_LANES), .MAX_PENDING(MAX_PENDING), .DIM_BITS(DIM_BITS), .TAG_W(TAG_W)
  ) cam (
    .ent_valid(ent_valid), .ent_mask(ent_mask), .ent_x(ent_x), .ent_y(ent_y),
    .in_mask(in_mask), .in_pos_x(in_pos_x), .in_pos_y(in_pos_y),
    .hazard(hazard), .has_free(has_free), .free_idx(free_idx)
  );
  assign in_ready = !hazard && has_free && (!out_valid || out_ready);
  assign fire = in_valid && in_ready;
  // a retire naming an idle slot is dropped, so a stale strobe after reset is harmless
  assign retire = done_valid && ent_valid[done_tag];
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= '0;
      out_valid <= 1'b0;
      out_tag <= '0;
      out_mask <= '0;
      out_data <= '0;
      pending_cnt <= '0;
    end else begin
      if (retire) ent_valid[done_tag] <= 1'b0;
      if (fire) begin
        ent_valid[free_idx] <= 1'b1;
        out_tag <= free_idx;
        out_mask <= in_mask;
        out_data <= in_data;
      end
      out_valid <= fire || (out_valid && !out_ready);
      pending_cnt <= pending_cnt + CNT_W'(fire) - CNT_W'(retire);
    end
  end
  always_ff @(posedge clk) begin
    if (fire) begin
      ent_mask[free_idx] <= in_mask;
      ent_x[free_idx] <= in_pos_x;
      ent_y[free_idx] <= in_pos_y;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && done_valid)
      assert (ent_valid[done_tag]) else $error("vx_om_hazard_sched: retire of idle tag %0d", done_tag);
  end
`ifdef VX_OM_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_hazard_stalls <= '0;
      perf_full_stalls <= '0;
    end else begin
      if (in_valid && hazard && !(&perf_hazard_stalls)) perf_hazard_stalls <= perf_hazard_stalls + 44'd1;
      if (in_valid && !hazard && !has_free && !(&perf_full_stalls)) perf_full_stalls <= perf_full_stalls + 44'd1;
    end
  end
`endif
endmodule
